// File: rtl/matrix_op_seq_if.sv
// Command and matrix_mem ALU-port bundle for matrix_op_seq.
// master = sequencer side, slave = command FSM plus matrix_mem side.
interface matrix_op_seq_if #(
    parameter int DW = 16
);
    logic          start;
    logic [1:0]    op;
    logic [1:0]    slot_a;
    logic [1:0]    slot_b;
    logic [1:0]    slot_c;
    logic [DW-1:0] scalar;
    logic          busy;
    logic          done;
    logic          err;

    logic [1:0]    mem_rd_slot;
    logic [2:0]    mem_rd_row;
    logic [2:0]    mem_rd_col;
    logic [DW-1:0] mem_rd_data;
    logic [2:0]    mem_cur_m;
    logic [2:0]    mem_cur_n;
    logic [1:0]    mem_wr_slot;
    logic [2:0]    mem_wr_row;
    logic [2:0]    mem_wr_col;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_we;
    logic [2:0]    mem_res_m;
    logic [2:0]    mem_res_n;
    logic          mem_dim_we;

    modport master (
        input  start, op, slot_a, slot_b, slot_c, scalar,
        input  mem_rd_data, mem_cur_m, mem_cur_n,
        output busy, done, err,
        output mem_rd_slot, mem_rd_row, mem_rd_col,
        output mem_wr_slot, mem_wr_row, mem_wr_col, mem_wr_data, mem_wr_we,
        output mem_res_m, mem_res_n, mem_dim_we
    );

    modport slave (
        output start, op, slot_a, slot_b, slot_c, scalar,
        output mem_rd_data, mem_cur_m, mem_cur_n,
        input  busy, done, err,
        input  mem_rd_slot, mem_rd_row, mem_rd_col,
        input  mem_wr_slot, mem_wr_row, mem_wr_col, mem_wr_data, mem_wr_we,
        input  mem_res_m, mem_res_n, mem_dim_we
    );
endinterface

// File: rtl/matrix_op_seq.sv
// Runs one ADD / TRANSPOSE / SCALAR_MUL / MATMUL over matrix_mem, one element
// access per cycle through the single combinational read port.
module matrix_op_seq #(
    parameter int DW      = 16,
    parameter int MAX_DIM = 5
) (
    input logic             clk,
    input logic             rst_n,
    matrix_op_seq_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LD_A, S_LD_B, S_CHECK, S_SETDIM,
        S_RD_A, S_RD_B, S_WR, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_TRN = 2'd1;
    localparam logic [1:0] OP_SCL = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d, slot_a_q, slot_a_d, slot_b_q, slot_b_d, slot_c_q, slot_c_d;
    logic [DW-1:0] scalar_q, scalar_d;
    logic [2:0]    am_q, am_d, an_q, an_d, bm_q, bm_d, bn_q, bn_d;
    logic [2:0]    rm_q, rm_d, rn_q, rn_d;
    logic [2:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [1:0]    rd_slot_q, rd_slot_d, wr_slot_q, wr_slot_d;
    logic [2:0]    rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic [2:0]    wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          cfg_err, last_i, last_j, last_k;

    function automatic logic dim_bad(input logic [2:0] d);
        return (d == 3'd0) || (int'(d) > MAX_DIM);
    endfunction

    function automatic logic [DW-1:0] mul_trunc(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        return p[DW-1:0];
    endfunction

    assign last_i = (i_q == rm_q - 3'd1);
    assign last_j = (j_q == rn_q - 3'd1);
    assign last_k = (k_q == an_q - 3'd1);

    always_comb begin
        cfg_err = 1'b0;
        unique case (op_q)
            OP_ADD:  cfg_err = dim_bad(am_q) || dim_bad(an_q) || dim_bad(bm_q) || dim_bad(bn_q)
                               || (am_q != bm_q) || (an_q != bn_q);
            OP_TRN:  cfg_err = dim_bad(am_q) || dim_bad(an_q) || (slot_c_q == slot_a_q);
            OP_SCL:  cfg_err = dim_bad(am_q) || dim_bad(an_q);
            default: cfg_err = dim_bad(am_q) || dim_bad(an_q) || dim_bad(bm_q) || dim_bad(bn_q)
                               || (an_q != bm_q) || (slot_c_q == slot_a_q) || (slot_c_q == slot_b_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0; slot_a_q <= '0; slot_b_q <= '0; slot_c_q <= '0;
            scalar_q  <= '0;
            am_q      <= '0; an_q <= '0; bm_q <= '0; bn_q <= '0;
            rm_q      <= '0; rn_q <= '0;
            i_q       <= '0; j_q <= '0; k_q <= '0;
            a_q       <= '0; b_q <= '0; acc_q <= '0;
            rd_slot_q <= '0; rd_row_q <= '0; rd_col_q <= '0;
            wr_slot_q <= '0; wr_row_q <= '0; wr_col_q <= '0; wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d; slot_a_q <= slot_a_d; slot_b_q <= slot_b_d; slot_c_q <= slot_c_d;
            scalar_q  <= scalar_d;
            am_q      <= am_d; an_q <= an_d; bm_q <= bm_d; bn_q <= bn_d;
            rm_q      <= rm_d; rn_q <= rn_d;
            i_q       <= i_d; j_q <= j_d; k_q <= k_d;
            a_q       <= a_d; b_q <= b_d; acc_q <= acc_d;
            rd_slot_q <= rd_slot_d; rd_row_q <= rd_row_d; rd_col_q <= rd_col_d;
            wr_slot_q <= wr_slot_d; wr_row_q <= wr_row_d; wr_col_q <= wr_col_d; wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LD_A;
            S_LD_A:   state_d = S_LD_B;
            S_LD_B:   state_d = S_CHECK;
            S_CHECK:  state_d = cfg_err ? S_ERR : S_SETDIM;
            S_SETDIM: state_d = S_RD_A;
            S_RD_A:   state_d = (op_q == OP_ADD || op_q == OP_MUL) ? S_RD_B : S_WR;
            S_RD_B:   state_d = (op_q == OP_MUL && !last_k) ? S_RD_A : S_WR;
            S_WR:     state_d = (last_i && last_j) ? S_DONE : S_RD_A;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand capture, dimension bookkeeping and element/k loop counters.
    always_comb begin
        op_d = op_q; slot_a_d = slot_a_q; slot_b_d = slot_b_q; slot_c_d = slot_c_q;
        scalar_d = scalar_q;
        am_d = am_q; an_d = an_q; bm_d = bm_q; bn_d = bn_q;
        rm_d = rm_q; rn_d = rn_q;
        i_d = i_q; j_d = j_q; k_d = k_q;
        a_d = a_q; b_d = b_q; acc_d = acc_q;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                op_d = bus.op; slot_a_d = bus.slot_a; slot_b_d = bus.slot_b;
                slot_c_d = bus.slot_c; scalar_d = bus.scalar;
            end
            S_LD_A: begin am_d = bus.mem_cur_m; an_d = bus.mem_cur_n; end
            S_LD_B: begin bm_d = bus.mem_cur_m; bn_d = bus.mem_cur_n; end
            S_CHECK: begin
                rm_d = (op_q == OP_TRN) ? an_q : am_q;
                rn_d = (op_q == OP_TRN) ? am_q : (op_q == OP_MUL) ? bn_q : an_q;
            end
            S_SETDIM: begin i_d = '0; j_d = '0; k_d = '0; acc_d = '0; end
            S_RD_A: a_d = bus.mem_rd_data;
            S_RD_B: begin
                b_d = bus.mem_rd_data;
                if (op_q == OP_MUL) begin
                    acc_d = acc_q + mul_trunc(a_q, bus.mem_rd_data);
                    if (!last_k) k_d = k_q + 3'd1;
                end
            end
            S_WR: begin
                k_d   = '0;
                acc_d = '0;
                if (last_j) begin
                    j_d = '0;
                    i_d = i_q + 3'd1;
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Address/data registers hold their last value whenever the port is idle.
    always_comb begin
        rd_slot_d = rd_slot_q; rd_row_d = rd_row_q; rd_col_d = rd_col_q;
        wr_slot_d = wr_slot_q; wr_row_d = wr_row_q; wr_col_d = wr_col_q; wr_data_d = wr_data_q;
        unique case (state_q)
            S_LD_A:   rd_slot_d = slot_a_q;
            S_LD_B:   rd_slot_d = slot_b_q;
            S_SETDIM: wr_slot_d = slot_c_q;
            S_RD_A: begin
                rd_slot_d = slot_a_q;
                rd_row_d  = (op_q == OP_TRN) ? j_q : i_q;
                rd_col_d  = (op_q == OP_TRN) ? i_q : (op_q == OP_MUL) ? k_q : j_q;
            end
            S_RD_B: begin
                rd_slot_d = slot_b_q;
                rd_row_d  = (op_q == OP_MUL) ? k_q : i_q;
                rd_col_d  = j_q;
            end
            S_WR: begin
                wr_slot_d = slot_c_q;
                wr_row_d  = i_q;
                wr_col_d  = j_q;
                unique case (op_q)
                    OP_ADD:  wr_data_d = a_q + b_q;
                    OP_TRN:  wr_data_d = a_q;
                    OP_SCL:  wr_data_d = mul_trunc(scalar_q, a_q);
                    default: wr_data_d = acc_q;
                endcase
            end
            default: ;
        endcase

        bus.busy        = (state_q != S_IDLE);
        bus.done        = (state_q == S_DONE) || (state_q == S_ERR);
        bus.err         = (state_q == S_ERR);
        bus.mem_wr_we   = (state_q == S_WR);
        bus.mem_dim_we  = (state_q == S_SETDIM);
        bus.mem_rd_slot = rd_slot_d;
        bus.mem_rd_row  = rd_row_d;
        bus.mem_rd_col  = rd_col_d;
        bus.mem_wr_slot = wr_slot_d;
        bus.mem_wr_row  = wr_row_d;
        bus.mem_wr_col  = wr_col_d;
        bus.mem_wr_data = wr_data_d;
        bus.mem_res_m   = rm_q;
        bus.mem_res_n   = rn_q;
    end
endmodule
